// File: rtl/coax_pkg.sv
// Shared definitions for the coax transmit sequencer: state encoding,
// default word width and the two-requester round-robin pick.
package coax_pkg;

    localparam int COAX_WORD_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE_HIGH,
        ST_PULSE_LOW,
        ST_SETTLE,
        ST_WAIT_WORD,
        ST_WAIT_DONE,
        ST_GAP
    } coax_state_t;

    // A lone request always wins; a tie goes to the side named by prio_req1.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio_req1);
        if (req == 2'b11) begin
            return prio_req1 ? 2'b10 : 2'b01;
        end
        return req;
    endfunction

endpackage

// File: rtl/coax_rr_arbiter.sv
// Two-way round-robin selector; the pointer favours the side not granted last
// and only moves when a frame is actually started.
module coax_rr_arbiter
    import coax_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

    logic       r_prio_req1;
    logic [1:0] w_gnt;

    assign w_gnt = rr_pick(i_req, r_prio_req1);
    assign o_gnt = w_gnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio_req1 <= 1'b0;
        end else if (i_update) begin
            r_prio_req1 <= w_gnt[0];
        end
    end

endmodule

// File: rtl/coax_tx_sequencer.sv
// Feeds words from two requesters into a coax transmitter holding register,
// one frame owner at a time, with a load pulse, settle time and inter-frame gap.
module coax_tx_sequencer
    import coax_pkg::*;
#(
    parameter int GAP_CLOCKS = 16,
    parameter int WORD_WIDTH = COAX_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [WORD_WIDTH-1:0] req0_data,
    input  logic                  req0_last,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [WORD_WIDTH-1:0] req1_data,
    input  logic                  req1_last,
    output logic                  req1_ready,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_load,
    input  logic                  tx_full,
    input  logic                  tx_active,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  underrun
);

    localparam int GAP_W = (GAP_CLOCKS > 0) ? $clog2(GAP_CLOCKS + 1) : 1;

    coax_state_t           r_state;
    logic [WORD_WIDTH-1:0] r_tx_data;
    logic                  r_tx_load;
    logic [1:0]            r_grant;
    logic                  r_underrun;
    logic                  r_last;
    logic                  r_seen_active;
    logic [GAP_W-1:0]      r_gap;

    logic [1:0]            w_req_valid;
    logic [1:0]            w_arb_gnt;
    logic                  w_idle_accept;
    logic                  w_word_accept;
    logic [1:0]            w_ready;
    logic [WORD_WIDTH-1:0] w_sel_data;
    logic                  w_sel_last;
    logic                  w_line_dropped;

    assign w_req_valid = {req1_valid, req0_valid};

    coax_rr_arbiter u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req    (w_req_valid),
        .i_update (w_idle_accept),
        .o_gnt    (w_arb_gnt)
    );

    // NOTE: ready is a same-cycle handshake, so it is decoded from state and gated by reset to stay low while reset is held.
    assign w_idle_accept = !reset && (r_state == ST_IDLE) && (|w_req_valid);
    assign w_word_accept = !reset && (r_state == ST_WAIT_WORD) && !tx_full
                           && (|(r_grant & w_req_valid));

    always_comb begin
        w_ready = 2'b00;
        if (w_idle_accept) begin
            w_ready = w_arb_gnt;
        end else if (w_word_accept) begin
            w_ready = r_grant;
        end
    end

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign w_sel_data = w_ready[1] ? req1_data : req0_data;
    assign w_sel_last = w_ready[1] ? req1_last : req0_last;

    // A line frame has ended once activity was observed and has since gone away.
    assign w_line_dropped = r_seen_active && !tx_active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_tx_data     <= '0;
            r_tx_load     <= 1'b0;
            r_grant       <= 2'b00;
            r_underrun    <= 1'b0;
            r_last        <= 1'b0;
            r_seen_active <= 1'b0;
            r_gap         <= '0;
        end else begin
            r_tx_load  <= 1'b0;
            r_underrun <= 1'b0;
            if (tx_active && (r_state != ST_IDLE) && (r_state != ST_GAP)) begin
                r_seen_active <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_idle_accept) begin
                        r_grant   <= w_arb_gnt;
                        r_tx_data <= w_sel_data;
                        r_last    <= w_sel_last;
                        r_tx_load <= 1'b1;
                        r_state   <= ST_PULSE_HIGH;
                    end
                end
                ST_PULSE_HIGH: r_state <= ST_PULSE_LOW;
                ST_PULSE_LOW:  r_state <= ST_SETTLE;
                ST_SETTLE:     r_state <= r_last ? ST_WAIT_DONE : ST_WAIT_WORD;
                ST_WAIT_WORD: begin
                    // The line frame closed early; later words open a fresh one.
                    if (w_line_dropped) begin
                        r_underrun    <= 1'b1;
                        r_seen_active <= 1'b0;
                    end
                    if (w_word_accept) begin
                        r_tx_data <= w_sel_data;
                        r_last    <= w_sel_last;
                        r_tx_load <= 1'b1;
                        r_state   <= ST_PULSE_HIGH;
                    end
                end
                ST_WAIT_DONE: begin
                    if (w_line_dropped) begin
                        r_grant       <= 2'b00;
                        r_seen_active <= 1'b0;
                        r_gap         <= GAP_W'(GAP_CLOCKS);
                        r_state       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap <= GAP_W'(1)) begin
                        r_gap   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_load  = r_tx_load;
    assign grant    = r_grant;
    assign underrun = r_underrun;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_coax_tx_sequencer.sv
// Directed bench for coax_tx_sequencer: reset, single and multi-word frames,
// contention, underrun and mid-frame reset, all with hand-derived expectations.
module tb_coax_tx_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [9:0] req0_data, req1_data;
    logic       req0_last, req1_last;
    logic       req0_ready, req1_ready;
    logic [9:0] tx_data;
    logic       tx_load;
    logic       tx_full, tx_active;
    logic [1:0] grant;
    logic       busy, underrun;

    int n_checks = 0;
    int n_errors = 0;
    int load_cnt = 0;
    int r0_rdy_cnt = 0;
    int both_rdy_cnt = 0;
    int underrun_cnt = 0;

    always #5 clk = ~clk;

    coax_tx_sequencer #(.GAP_CLOCKS(16), .WORD_WIDTH(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_full    (tx_full),
        .tx_active  (tx_active),
        .grant      (grant),
        .busy       (busy),
        .underrun   (underrun)
    );

    always @(posedge clk) begin
        if (tx_load === 1'b1) load_cnt++;
        if (req0_ready === 1'b1) r0_rdy_cnt++;
        if (req0_ready === 1'b1 && req1_ready === 1'b1) both_rdy_cnt++;
        if (underrun === 1'b1) underrun_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_ready(input int which, input int limit, output int cyc);
        cyc = 0;
        #1;
        while (((which == 0) ? req0_ready : req1_ready) !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_not_busy(output int cyc);
        cyc = 0;
        while (busy !== 1'b0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req0_data = 10'h3FF; req0_last = 1'b1;
        req1_valid = 1'b1; req1_data = 10'h3FF; req1_last = 1'b1;
        tx_full = 1'b0; tx_active = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (tx_load !== 1'b0) begin n_errors++; $display("FAIL rst_load: got %b want 0", tx_load); end
        n_checks++; if (tx_data !== 10'h000) begin n_errors++; $display("FAIL rst_data: got %h want 000", tx_data); end
        n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL rst_grant: got %b want 00", grant); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL rst_underrun: got %b want 0", underrun); end
        n_checks++; if (req0_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready1: got %b want 0", req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        // First tie after reset must go to req0; valids drop before the edge so nothing is accepted.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL tie_ready0: got %b want 1", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_errors++; $display("FAIL tie_ready1: got %b want 0", req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        int cyc;
        int l0;
        l0 = load_cnt;
        req0_valid = 1'b1; req0_data = 10'h2A5; req0_last = 1'b1;
        wait_ready(0, 4, cyc);
        n_checks++; if (cyc !== 0) begin n_errors++; $display("FAIL single_accept_wait: got %0d want 0", cyc); end
        @(negedge clk);
        req0_valid = 1'b0; req0_data = 10'h000;
        n_checks++; if (tx_load !== 1'b1) begin n_errors++; $display("FAIL single_load: got %b want 1", tx_load); end
        n_checks++; if (tx_data !== 10'h2A5) begin n_errors++; $display("FAIL single_data: got %h want 2a5", tx_data); end
        n_checks++; if (grant !== 2'b01) begin n_errors++; $display("FAIL single_grant: got %b want 01", grant); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy: got %b want 1", busy); end
        tx_active = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_load !== 1'b0) begin n_errors++; $display("FAIL single_load_low: got %b want 0", tx_load); end
        n_checks++; if (tx_data !== 10'h2A5) begin n_errors++; $display("FAIL single_data_hold: got %h want 2a5", tx_data); end
        repeat (3) @(negedge clk);
        n_checks++; if (grant !== 2'b01) begin n_errors++; $display("FAIL single_grant_wait: got %b want 01", grant); end
        tx_active = 1'b0;
        @(negedge clk);
        n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL single_grant_clear: got %b want 00", grant); end
        cyc = 0;
        while (busy === 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        n_checks++; if (cyc !== 16) begin n_errors++; $display("FAIL single_gap_len: got %0d want 16", cyc); end
        n_checks++; if (load_cnt - l0 !== 1) begin n_errors++; $display("FAIL single_load_count: got %0d want 1", load_cnt - l0); end
    endtask

    task automatic test_multi_word();
        int cyc;
        int blocked;
        int r0_base;
        int u_base;
        u_base = underrun_cnt;
        req1_valid = 1'b1; req1_data = 10'h1A1; req1_last = 1'b0;
        wait_ready(1, 4, cyc);
        @(negedge clk);
        n_checks++; if (tx_data !== 10'h1A1) begin n_errors++; $display("FAIL multi_w1_data: got %h want 1a1", tx_data); end
        n_checks++; if (grant !== 2'b10) begin n_errors++; $display("FAIL multi_grant: got %b want 10", grant); end
        r0_base = r0_rdy_cnt;
        req0_valid = 1'b1; req0_data = 10'h0FF; req0_last = 1'b1;
        tx_active = 1'b1;
        req1_data = 10'h1A2;
        wait_ready(1, 10, cyc);
        n_checks++; if (cyc !== 3) begin n_errors++; $display("FAIL multi_w2_spacing: got %0d want 3", cyc); end
        @(negedge clk);
        n_checks++; if (tx_load !== 1'b1 || tx_data !== 10'h1A2) begin n_errors++; $display("FAIL multi_w2_load: got load=%b data=%h want load=1 data=1a2", tx_load, tx_data); end
        tx_full = 1'b1;
        req1_data = 10'h1A3; req1_last = 1'b1;
        blocked = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (req1_ready === 1'b1) blocked++;
        end
        n_checks++; if (blocked !== 0) begin n_errors++; $display("FAIL multi_full_block: got %0d readies want 0", blocked); end
        n_checks++; if (tx_data !== 10'h1A2) begin n_errors++; $display("FAIL multi_data_held: got %h want 1a2", tx_data); end
        tx_full = 1'b0;
        wait_ready(1, 3, cyc);
        n_checks++; if (cyc !== 0) begin n_errors++; $display("FAIL multi_w3_release: got %0d want 0", cyc); end
        @(negedge clk);
        req1_valid = 1'b0;
        n_checks++; if (tx_load !== 1'b1 || tx_data !== 10'h1A3) begin n_errors++; $display("FAIL multi_w3_load: got load=%b data=%h want load=1 data=1a3", tx_load, tx_data); end
        repeat (4) @(negedge clk);
        tx_active = 1'b0;
        cyc = 0;
        while (grant !== 2'b00 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL multi_end: got grant %b want 00", grant); end
        n_checks++; if (r0_rdy_cnt - r0_base !== 0) begin n_errors++; $display("FAIL multi_req0_mid: got %0d readies want 0", r0_rdy_cnt - r0_base); end
        n_checks++; if (underrun_cnt - u_base !== 0) begin n_errors++; $display("FAIL multi_underrun: got %0d want 0", underrun_cnt - u_base); end
        req0_valid = 1'b0;
        wait_not_busy(cyc);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL multi_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt [4];
        int cyc;
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
        req0_valid = 1'b1; req0_data = 10'h0C0; req0_last = 1'b1;
        req1_valid = 1'b1; req1_data = 10'h3C1; req1_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc = 0;
            @(negedge clk);
            while (tx_load !== 1'b1 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            n_checks++; if (grant !== exp_gnt[i]) begin n_errors++; $display("FAIL contend_grant%0d: got %b want %b", i, grant, exp_gnt[i]); end
            n_checks++; if (tx_data !== ((exp_gnt[i] == 2'b01) ? 10'h0C0 : 10'h3C1)) begin n_errors++; $display("FAIL contend_data%0d: got %h", i, tx_data); end
            if (i == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            tx_active = 1'b1;
            repeat (3) @(negedge clk);
            tx_active = 1'b0;
        end
        wait_not_busy(cyc);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL contend_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_underrun();
        int cyc;
        int u_base;
        u_base = underrun_cnt;
        req0_valid = 1'b1; req0_data = 10'h111; req0_last = 1'b0;
        wait_ready(0, 4, cyc);
        @(negedge clk);
        req0_valid = 1'b0;
        tx_active = 1'b1;
        repeat (4) @(negedge clk);
        tx_active = 1'b0;
        @(negedge clk);
        n_checks++; if (underrun !== 1'b1) begin n_errors++; $display("FAIL under_pulse: got %b want 1", underrun); end
        n_checks++; if (busy !== 1'b1 || grant !== 2'b01) begin n_errors++; $display("FAIL under_continue: got busy=%b grant=%b want 1 01", busy, grant); end
        @(negedge clk);
        n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL under_one_cycle: got %b want 0", underrun); end
        repeat (3) @(negedge clk);
        n_checks++; if (underrun_cnt - u_base !== 1) begin n_errors++; $display("FAIL under_count: got %0d want 1", underrun_cnt - u_base); end
        req0_valid = 1'b1; req0_data = 10'h222; req0_last = 1'b1;
        wait_ready(0, 4, cyc);
        n_checks++; if (cyc !== 0) begin n_errors++; $display("FAIL under_resume_wait: got %0d want 0", cyc); end
        @(negedge clk);
        req0_valid = 1'b0;
        n_checks++; if (tx_load !== 1'b1 || tx_data !== 10'h222) begin n_errors++; $display("FAIL under_resume_load: got load=%b data=%h want 1 222", tx_load, tx_data); end
        tx_active = 1'b1;
        repeat (3) @(negedge clk);
        tx_active = 1'b0;
        @(negedge clk);
        n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL under_frame_done: got %b want 00", grant); end
        n_checks++; if (underrun_cnt - u_base !== 1) begin n_errors++; $display("FAIL under_count_end: got %0d want 1", underrun_cnt - u_base); end
        wait_not_busy(cyc);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL under_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        int l0;
        req0_valid = 1'b1; req0_data = 10'h155; req0_last = 1'b1;
        wait_ready(0, 4, cyc);
        @(negedge clk);
        n_checks++; if (tx_load !== 1'b1) begin n_errors++; $display("FAIL rmid_pre_load: got %b want 1", tx_load); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (tx_load !== 1'b0) begin n_errors++; $display("FAIL rmid_load: got %b want 0", tx_load); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL rmid_grant: got %b want 00", grant); end
        n_checks++; if (tx_data !== 10'h000) begin n_errors++; $display("FAIL rmid_data: got %h want 000", tx_data); end
        req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        l0 = load_cnt;
        repeat (6) @(negedge clk);
        n_checks++; if (load_cnt - l0 !== 0) begin n_errors++; $display("FAIL rmid_no_pulse: got %0d want 0", load_cnt - l0); end
        req1_valid = 1'b1; req1_data = 10'h2AA; req1_last = 1'b1;
        wait_ready(1, 4, cyc);
        n_checks++; if (cyc !== 0) begin n_errors++; $display("FAIL rmid_req1_wait: got %0d want 0", cyc); end
        @(negedge clk);
        req1_valid = 1'b0;
        n_checks++; if (grant !== 2'b10 || tx_data !== 10'h2AA) begin n_errors++; $display("FAIL rmid_req1_grant: got grant=%b data=%h want 10 2aa", grant, tx_data); end
        tx_active = 1'b1;
        repeat (3) @(negedge clk);
        tx_active = 1'b0;
        wait_not_busy(cyc);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rmid_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_invariants();
        n_checks++; if (both_rdy_cnt !== 0) begin n_errors++; $display("FAIL both_ready: got %0d cycles want 0", both_rdy_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_word();
        test_contention();
        test_underrun();
        test_reset_mid_frame();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
